// File: rtl/signal_frame_capture.sv
// ============================================================================
// Module   : signal_frame_capture
// Captures framed sample bursts into a ping-pong buffer and exposes them via
// a random-access read port with a release handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module signal_frame_capture #(
  parameter int FRAME_LEN = 2048,
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              frame_ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              frame_release,
  output logic [15:0]       frame_count,
  output logic [7:0]        drop_count,
  output logic              short_pulse,
  output logic              overflow_pulse
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DROP = 2'd2
  } wr_state_e;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

  wr_state_e         state_q, state_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [1:0]        full_q, full_d;
  logic              frame_ready_q, frame_ready_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic [7:0]        drop_count_q, drop_count_d;
  logic              short_q, short_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] rd_data_q;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_idx;
  logic              drop_evt;

  logic [DATA_W-1:0] mem [2*FRAME_LEN];

  always_comb begin
    state_d       = state_q;
    wr_cnt_d      = wr_cnt_q;
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    full_d        = full_q;
    frame_count_d = frame_count_q;
    drop_count_d  = drop_count_q;
    short_d       = 1'b0;
    ovf_d         = 1'b0;
    wr_en         = 1'b0;
    wr_idx        = '0;
    drop_evt      = 1'b0;
    frame_ready_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Overflow is judged on the flags as they stood before this cycle's release.
        if (sample_valid) begin
          if (!full_q[wr_bank_q]) begin
            wr_en    = 1'b1;
            wr_idx   = '0;
            wr_cnt_d = ADDR_W'(1);
            state_d  = ST_FILL;
          end else begin
            ovf_d    = 1'b1;
            drop_evt = 1'b1;
            state_d  = ST_DROP;
          end
        end
      end
      ST_FILL: begin
        if (sample_valid) begin
          wr_en  = 1'b1;
          wr_idx = wr_cnt_q;
          if (wr_cnt_q == LAST_IDX) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
            wr_cnt_d          = '0;
            frame_count_d     = frame_count_q + 16'd1;
            state_d           = ST_IDLE;
          end else begin
            wr_cnt_d = wr_cnt_q + ADDR_W'(1);
          end
        end else begin
          short_d  = 1'b1;
          drop_evt = 1'b1;
          wr_cnt_d = '0;
          state_d  = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (!sample_valid) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        wr_cnt_d = '0;
      end
    endcase

    if (drop_evt && (drop_count_q != 8'hFF)) begin
      drop_count_d = drop_count_q + 8'd1;
    end

    // The write side never completes into a full bank, so set and clear cannot collide.
    if (frame_release && frame_ready_q) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end

    frame_ready_d = full_d[rd_bank_d];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      wr_cnt_q      <= '0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      full_q        <= 2'b00;
      frame_ready_q <= 1'b0;
      frame_count_q <= '0;
      drop_count_q  <= '0;
      short_q       <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_cnt_q      <= wr_cnt_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      full_q        <= full_d;
      frame_ready_q <= frame_ready_d;
      frame_count_q <= frame_count_d;
      drop_count_q  <= drop_count_d;
      short_q       <= short_d;
      ovf_q         <= ovf_d;
    end
  end

  // Storage kept free of reset so it maps onto a simple dual-port block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_bank_q, wr_idx}] <= sample_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem[{rd_bank_q, rd_addr}];
    end
  end

  assign frame_ready    = frame_ready_q;
  assign rd_data        = rd_data_q;
  assign frame_count    = frame_count_q;
  assign drop_count     = drop_count_q;
  assign short_pulse    = short_q;
  assign overflow_pulse = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_signal_frame_capture.sv
// ============================================================================
// Module   : tb_signal_frame_capture
// Directed self-checking bench for signal_frame_capture.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_signal_frame_capture;

  localparam int FRAME_LEN = 2048;
  localparam int ADDR_W    = 11;
  localparam int DATA_W    = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] sample_in;
  logic              sample_valid;
  logic              frame_ready;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              frame_release;
  logic [15:0]       frame_count;
  logic [7:0]        drop_count;
  logic              short_pulse;
  logic              overflow_pulse;

  int n_checks = 0;
  int n_fail   = 0;
  int n_short  = 0;
  int n_ovf    = 0;
  int n_both   = 0;

  always #5 clk = ~clk;

  signal_frame_capture #(
    .FRAME_LEN(FRAME_LEN),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .sample_in     (sample_in),
    .sample_valid  (sample_valid),
    .frame_ready   (frame_ready),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .frame_release (frame_release),
    .frame_count   (frame_count),
    .drop_count    (drop_count),
    .short_pulse   (short_pulse),
    .overflow_pulse(overflow_pulse)
  );

  always @(negedge clk) begin
    if (short_pulse) n_short++;
    if (overflow_pulse) n_ovf++;
    if (short_pulse && overflow_pulse) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    sample_valid  = 1'b0;
    sample_in     = '0;
    rd_en         = 1'b0;
    rd_addr       = '0;
    frame_release = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Drives n consecutive valid samples base+i; optionally pulses release on the last one.
  task automatic send_burst(input int n, input logic [15:0] base, input bit rel_on_last);
    for (int i = 0; i < n; i++) begin
      sample_valid  = 1'b1;
      sample_in     = base + 16'(i);
      frame_release = rel_on_last && (i == n - 1);
      tick();
    end
    frame_release = 1'b0;
  endtask

  task automatic gap();
    sample_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic read(input logic [ADDR_W-1:0] addr, output logic [DATA_W-1:0] data);
    rd_en   = 1'b1;
    rd_addr = addr;
    tick();
    rd_en = 1'b0;
    data  = rd_data;
  endtask

  task automatic release_frame();
    frame_release = 1'b1;
    tick();
    frame_release = 1'b0;
  endtask

  initial begin
    logic [DATA_W-1:0] d;
    int s0, o0;

    // 1: reset state and first full frame
    do_reset();
    check("rst_ready", 32'(frame_ready), 0);
    check("rst_fcnt", 32'(frame_count), 0);
    check("rst_dcnt", 32'(drop_count), 0);
    check("rst_short", 32'(short_pulse), 0);
    check("rst_ovf", 32'(overflow_pulse), 0);
    check("rst_rdata", 32'(rd_data), 0);
    send_burst(FRAME_LEN - 1, 16'h0000, 1'b0);
    check("t1_ready_before_last", 32'(frame_ready), 0);
    send_burst(1, 16'(FRAME_LEN - 1), 1'b0);
    check("t1_ready", 32'(frame_ready), 1);
    check("t1_fcnt", 32'(frame_count), 1);
    gap();
    read(11'd0, d);    check("t1_rd0", 32'(d), 32'd0);
    read(11'd1000, d); check("t1_rd1000", 32'(d), 32'd1000);
    read(11'd2047, d); check("t1_rd2047", 32'(d), 32'd2047);
    rd_addr = 11'd5;
    tick();
    check("t1_rd_hold", 32'(rd_data), 32'd2047);

    // 2: short burst then full frame into bank 0
    do_reset();
    s0 = n_short;
    send_burst(100, 16'h0000, 1'b0);
    gap();
    check("t2_short_cnt", 32'(n_short - s0), 1);
    check("t2_dcnt", 32'(drop_count), 1);
    check("t2_ready", 32'(frame_ready), 0);
    send_burst(FRAME_LEN, 16'h1000, 1'b0);
    gap();
    check("t2_ready2", 32'(frame_ready), 1);
    read(11'd5, d); check("t2_rd5", 32'(d), 32'h1005);

    // 3: overflow with both banks full, then two releases
    do_reset();
    o0 = n_ovf;
    send_burst(FRAME_LEN, 16'h0000, 1'b0); sample_valid = 1'b0; tick();
    send_burst(FRAME_LEN, 16'h1000, 1'b0); sample_valid = 1'b0; tick();
    send_burst(FRAME_LEN, 16'h2000, 1'b0);
    gap();
    check("t3_ovf_cnt", 32'(n_ovf - o0), 1);
    check("t3_dcnt", 32'(drop_count), 1);
    check("t3_fcnt", 32'(frame_count), 2);
    read(11'd3, d); check("t3_rd3_b0", 32'(d), 32'h0003);
    release_frame();
    check("t3_ready_after_rel1", 32'(frame_ready), 1);
    read(11'd3, d); check("t3_rd3_b1", 32'(d), 32'h1003);
    release_frame();
    check("t3_ready_after_rel2", 32'(frame_ready), 0);
    release_frame();
    check("t3_rel_ignored", 32'(frame_ready), 0);

    // 4: 4096 contiguous samples form two frames
    do_reset();
    s0 = n_short;
    send_burst(2 * FRAME_LEN, 16'h0000, 1'b0);
    gap();
    check("t4_fcnt", 32'(frame_count), 2);
    check("t4_short_cnt", 32'(n_short - s0), 0);
    check("t4_dcnt", 32'(drop_count), 0);
    read(11'd0, d);    check("t4_b0_rd0", 32'(d), 32'd0);
    read(11'd2047, d); check("t4_b0_rd2047", 32'(d), 32'd2047);
    release_frame();
    read(11'd0, d);    check("t4_b1_rd0", 32'(d), 32'd2048);
    read(11'd2047, d); check("t4_b1_rd2047", 32'(d), 32'd4095);

    // 5: reset mid-fill, then clean capture into bank 0
    do_reset();
    send_burst(FRAME_LEN, 16'h0000, 1'b0);
    sample_valid = 1'b0; tick();
    read(11'd1, d);
    send_burst(1000, 16'h4000, 1'b0);
    reset = 1'b1;
    sample_valid = 1'b1;
    tick();
    check("t5_ready", 32'(frame_ready), 0);
    check("t5_fcnt", 32'(frame_count), 0);
    check("t5_dcnt", 32'(drop_count), 0);
    check("t5_short", 32'(short_pulse), 0);
    check("t5_ovf", 32'(overflow_pulse), 0);
    check("t5_rdata", 32'(rd_data), 0);
    reset = 1'b0;
    sample_valid = 1'b0;
    tick();
    send_burst(FRAME_LEN, 16'h5000, 1'b0);
    gap();
    check("t5_ready2", 32'(frame_ready), 1);
    check("t5_fcnt2", 32'(frame_count), 1);
    read(11'd7, d); check("t5_rd7", 32'(d), 32'h5007);

    // 6: release coincides with completion of the second frame
    do_reset();
    send_burst(FRAME_LEN, 16'h6000, 1'b0);
    sample_valid = 1'b0; tick();
    check("t6_ready1", 32'(frame_ready), 1);
    send_burst(FRAME_LEN, 16'h7000, 1'b1);
    check("t6_ready2", 32'(frame_ready), 1);
    check("t6_fcnt", 32'(frame_count), 2);
    sample_valid = 1'b0; tick();
    read(11'd9, d); check("t6_rd9", 32'(d), 32'h7009);
    release_frame();
    check("t6_ready_empty", 32'(frame_ready), 0);

    // 7: drop counter saturation
    do_reset();
    s0 = n_short;
    for (int k = 0; k < 260; k++) begin
      send_burst(1, 16'h0000, 1'b0);
      sample_valid = 1'b0;
      tick();
    end
    tick();
    check("t7_dcnt_sat", 32'(drop_count), 255);
    check("t7_short_cnt", 32'(n_short - s0), 260);
    check("t7_ready", 32'(frame_ready), 0);
    check("no_pulse_overlap", 32'(n_both), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
